// File: rtl/adc733_sample_fifo.sv
// Block averager for ADC733 samples feeding a show-ahead FIFO with a registered head word.
// Averages of 2^AVG_LOG2 samples are pushed; a full FIFO drops the word and sets sticky overflow.
module adc733_sample_fifo #(
    parameter int DEPTH    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              sample_i,
    input  logic                     sample_vld_i,
    input  logic                     sync_i,
    input  logic                     enable_i,
    output logic [15:0]              out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int AW = 16 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        PUSH  = 2'b10
    } state_t;

    state_t               r_state, w_state_nxt;
    logic signed [AW-1:0] r_acc, w_acc_nxt, w_acc_base, w_sample_ext, w_sum, w_avg;
    logic [CW-1:0]        r_cnt, w_cnt_nxt, w_cnt_base;
    logic [15:0]          r_push, w_push_nxt;

    logic [15:0]          r_mem [DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr, w_rd_inc;
    logic [LW-1:0]        r_level, w_level_nxt;
    logic [15:0]          r_head, w_head_nxt;
    logic                 r_valid, r_ovf;
    logic                 w_push_req, w_pop, w_full, w_push_ok, w_drop;

    // Averager next-state: PUSH shares the sample path because acc/cnt are already cleared on entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_push_nxt   = r_push;
        w_acc_base   = sync_i ? {AW{1'b0}} : r_acc;
        w_cnt_base   = sync_i ? {CW{1'b0}} : r_cnt;
        w_sample_ext = AW'($signed(sample_i));
        w_sum        = w_acc_base + w_sample_ext;
        w_avg        = w_sum >>> AVG_LOG2;
        case (r_state)
            IDLE: begin
                w_acc_nxt = {AW{1'b0}};
                w_cnt_nxt = {CW{1'b0}};
                if (enable_i) begin
                    w_state_nxt = ACCUM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCUM, PUSH: begin
                if (!enable_i) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = {AW{1'b0}};
                    w_cnt_nxt   = {CW{1'b0}};
                end else if (sample_vld_i) begin
                    if (w_cnt_base == LAST_CNT) begin
                        w_push_nxt  = w_avg[15:0];
                        w_acc_nxt   = {AW{1'b0}};
                        w_cnt_nxt   = {CW{1'b0}};
                        w_state_nxt = PUSH;
                    end else begin
                        w_acc_nxt   = w_sum;
                        w_cnt_nxt   = w_cnt_base + CW'(1'b1);
                        w_state_nxt = ACCUM;
                    end
                end else begin
                    w_acc_nxt   = w_acc_base;
                    w_cnt_nxt   = w_cnt_base;
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_acc_nxt   = {AW{1'b0}};
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Averager state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= {AW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_push  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_push  <= w_push_nxt;
        end
    end

    assign w_push_req = (r_state == PUSH);
    assign w_pop      = r_valid & out_ready_i;
    assign w_full     = (r_level == FULL_LVL);
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_rd_inc   = r_rd_ptr + PW'(1'b1);

    // Head word and occupancy; a push into a one-deep pop bypasses straight to the head.
    always_comb begin
        w_head_nxt  = r_head;
        w_level_nxt = r_level;
        if (w_pop) begin
            if (r_level > ONE_LVL) begin
                w_head_nxt = r_mem[w_rd_inc];
            end else if (w_push_ok) begin
                w_head_nxt = r_push;
            end else begin
                w_head_nxt = r_head;
            end
        end else if (w_push_ok && (r_level == {LW{1'b0}})) begin
            w_head_nxt = r_push;
        end else begin
            w_head_nxt = r_head;
        end
        case ({w_push_ok, w_pop})
            2'b10:   w_level_nxt = r_level + ONE_LVL;
            2'b01:   w_level_nxt = r_level - ONE_LVL;
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_push;
        end
    end

    // FIFO pointers, occupancy, head register and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {LW{1'b0}};
            r_head   <= 16'h0000;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            r_level <= w_level_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_level_nxt != {LW{1'b0}});
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_data_o  = r_head;
    assign out_valid_o = r_valid;
    assign level_o     = r_level;
    assign overflow_o  = r_ovf;
endmodule

// File: doc/adc733_sample_fifo.md
Name: adc733_sample_fifo

Overview:
Downstream stage of the ADC733 serial wrapper. It takes the 16-bit two's-complement sample word and a one-cycle new-sample strobe, and averages blocks of 2^AVG_LOG2 samples. Each block average goes into a show-ahead FIFO drained by a valid/ready consumer (DSP or host bus bridge). Single clock domain, same clk as the wrapper's data_o register.

Parameters:
DEPTH, 16, FIFO depth in words; power of two, 2..256.
AVG_LOG2, 2, log2 of samples per average; 0..4 (0 = pass-through, every sample pushed).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sample_i  in  16  signed sample word from the ADC wrapper
sample_vld_i  in  1  one-cycle strobe; sample_i is valid this cycle
sync_i  in  1  block realign; discards the partial accumulation
enable_i  in  1  accumulation enable
out_data_o  out  16  FIFO head word (signed average)
out_valid_o  out  1  FIFO non-empty
out_ready_i  in  1  consumer accepts the head word when out_valid_o=1
level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
overflow_o  out  1  sticky; an average was dropped because the FIFO was full
clr_ovf_i  in  1  clears overflow_o

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, cnt=0, FIFO empty. Outputs: out_data_o=0, out_valid_o=0, level_o=0, overflow_o=0. This applies at any point, including mid-block and mid-drain; in-flight data is lost.
- Accumulator: signed, 16+AVG_LOG2 bits, sign-extended adds, so it never wraps. avg = (acc + sample_i) >>> AVG_LOG2, arithmetic shift, which rounds toward minus infinity. Take the low 16 bits.
- FSM states:
  IDLE: acc=0, cnt=0. Go to ACCUM when enable_i=1.
  ACCUM: on sample_vld_i, add sample_i and increment cnt. When the strobe carries sample number 2^AVG_LOG2, latch avg into push_reg and go to PUSH.
  PUSH: one cycle. Write push_reg to the FIFO on the clock edge ending this cycle. Return to ACCUM, or to IDLE if enable_i=0. A sample_vld_i during PUSH starts the next block: acc=sample, cnt=1.
  enable_i=0 in any state other than PUSH: go to IDLE and clear acc/cnt next cycle. PUSH still completes its write.
- sync_i (ACCUM or PUSH): clears acc and cnt. A coincident sample_vld_i is loaded as the first sample (acc=sample, cnt=1). Any PUSH in progress still completes. sync_i is ignored in IDLE.
- Latency: final sample strobe at cycle N -> PUSH at cycle N+1 -> FIFO written at the end of N+1. If the FIFO was empty, out_valid_o=1 and out_data_o=avg in cycle N+2.
- FIFO: show-ahead. out_data_o is the head word, registered.
  - Pop occurs when out_valid_o & out_ready_i. The next word (or hold if none) is presented the following cycle.
  - out_ready_i is ignored when empty.
  - Read/write pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy is tracked separately.
- Full (level_o=DEPTH) during PUSH:
  - With no pop that cycle: the word is dropped, FIFO contents are unchanged, and overflow_o=1 from the next cycle.
  - With a pop the same cycle: the push is accepted and level_o stays DEPTH.
- Simultaneous push and pop when not full or empty: level_o unchanged.
- Push into empty with no pop: level_o 0->1.
- overflow_o: stays 1 until clr_ovf_i=1. If clr_ovf_i and a new drop coincide, the set wins.
- out_data_o holds its last value when empty. Benches check it only when out_valid_o=1.

Test Plan:
- AVG_LOG2=2, enable=1, ready=1; strobes 100,200,300,400 -> out_valid_o=1 two cycles after the 4th strobe, out_data_o=250, single-cycle pop, level_o returns to 0.
- Negatives -1,-2,-3,-4 -> out_data_o=0xFFFD (-3, floor of -2.5). Extremes 4x 0x7FFF -> 0x7FFF; 4x 0x8000 -> 0x8000 (no wrap).
- out_ready_i=0; 17 blocks with DEPTH=16 -> level_o=16, overflow_o=1 after the 17th PUSH. Drain gives the first 16 averages in order. clr_ovf_i pulse -> overflow_o=0.
- sync_i coincident with the 3rd strobe of a block (samples 10,20,|30,40,50,60) -> single output 45; the first two samples are discarded.
- FIFO full, PUSH and pop in the same cycle -> level_o stays 16, the new average lands at the tail, overflow_o stays 0.
- rst pulse mid-block (after 2 strobes) with 3 words queued -> next cycle out_valid_o=0, level_o=0. The next 4 strobes yield a fresh average unaffected by the pre-reset samples.
